alu181_serial: RTL and testbench
================================

// Module: alu181_serial
// PURPOSE
//  Parametrised, registered successor of the 4-bit 181-style ALU slice: WIDTH-bit operands processed
//  nibble-serially, one 4-bit slice per clock, least significant first, carry rippled slice to slice.
//  Valid/ready handshake on both sides, registered result and flags.
//  Sits between the operand switches/registers and the result display in the teaching datapath.
// PARAMETERS
//  WIDTH     16     operand/result width; multiple of 4, range 4..32; NSLICE = WIDTH/4 (localparam)
//  SCAN_DIV  50000  display digit-scan period in clocks (used only with ALU181_DISP_EN)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operation request
//  in_ready   out  1        request accepted when in_valid && in_ready
//  a_i, b_i   in   WIDTH    operands
//  s_i        in   4        function select
//  m_i        in   1        1 = logic, 0 = arithmetic
//  cn_n_i     in   1        active-low carry-in (0 = add 1); ignored when m_i = 1
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        result consumed when out_valid && out_ready
//  f_o        out  WIDTH    result
//  co_o       out  1        true carry out of MSB slice (arith); 0 in logic mode
//  zero_o     out  1        f_o == 0
//  aeqb_o     out  1        f_o all ones (A=B indication when s=6, m=0, cn_n=1)
//  seg_o      out  8        {dp,g..a} active-high segments   [ALU181_DISP_EN only]
//  dig_o      out  NSLICE   active-low digit enables         [ALU181_DISP_EN only]
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, f_o=0, co_o=0, zero_o=0, aeqb_o=0; takes effect immediately.
//  FSM: IDLE --accept--> RUN --NSLICE slices done--> DONE --out_ready--> IDLE.
//   IDLE: in_ready=1; on accept latch a,b,s,m,cin=~cn_n_i; slice index k=0.
//   RUN: one slice per cycle: nibble k of F from 4-bit slice (operands nibble k, carry c_k); c_{k+1} saved; k++.
//   DONE: out_valid=1; f_o/flags stable; in_ready=0. Back-to-back: new accept possible the cycle after handshake.
//  Latency: accept edge -> out_valid high after exactly NSLICE+1 rising edges (WIDTH=16: 5).
//  Logic (m=1), per bit: 0 ~A; 1 ~(A|B); 2 ~A&B; 3 all0; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B;
//   8 ~A|B; 9 ~(A^B); A B; B A&B; C all1; D A|~B; E A|B; F A. No carry.
//  Arith (m=0): F = P + Q + cin, modulo 2^WIDTH, all terms bitwise so slicing is exact. (P,Q) by s:
//   0 (A,0) 1 (A|B,0) 2 (A|~B,0) 3 (0,1s) 4 (A,A&~B) 5 (A|B,A&~B) 6 (A,~B) 7 (A&~B,1s)
//   8 (A,A&B) 9 (A,B) A (A|~B,A&B) B (A&B,1s) C (A,A) D (A|B,A) E (A|~B,A) F (A,1s)   [1s = all ones]
//  co_o = carry out of slice NSLICE-1; flags computed on the full result when entering DONE.
//  Inputs changing during RUN/DONE have no effect; in_valid in RUN/DONE is not accepted.
//  Reset mid-RUN/DONE: operation discarded, all outputs to reset values, no partial result visible.
// CONFIGURATION
//  ALU181_DISP_EN defined: seg_o/dig_o present; scan counter steps one digit every SCAN_DIV clocks,
//   digit k (dig_o[k]=0, others 1) shows hex nibble k of the last completed f_o (0 after reset);
//   font gfedcba hex 0-F, dp off; reset: dig_o all ones, seg_o=0, scan index 0, wraps NSLICE-1 -> 0.
//  Undefined: ports seg_o/dig_o absent, no scan counter; core behaviour identical.
// STRUCTURE
//  Package alu181_pkg: state enum {IDLE,RUN,DONE}, S_* function codes, seg7_hex() font function.
//  Sub-module alu181_slice: combinational 4-bit slice (a,b,s,m,cin -> f,cout); instantiated once, time-shared.
// TESTING (WIDTH=16, SCAN_DIV=4)
//  s=9,m=0,cn_n=1,A=FFFF,B=0001 -> 5 cycles later f=0000, co=1, zero=1, aeqb=0.
//  s=6,m=0,A=B=1234: cn_n=0 -> f=0000, co=1, zero=1; cn_n=1 -> f=FFFF, co=0, aeqb=1.
//  s=6,m=1,A=F0F0,B=FF00,cn_n=0 -> f=0FF0, co=0; s=3,m=1 -> f=0000, zero=1.
//  out_ready low 10 cycles after out_valid -> f_o/flags stable, in_ready=0; next accept 1 cycle after handshake.
//  rst_n low at 2nd RUN cycle -> out_valid=0, f_o=0, in_ready=1 immediately; no stale result after release.
//  DISP_EN, f=ABCD -> dig_o cycles E,D,B,7 every 4 clocks with seg_o 5E,7C,39,77 (D,C,B,A).

Source files
------------

// File: rtl/alu181_pkg.sv
// -----------------------------------------------------------------------------
// alu181_pkg
// Shared definitions for the nibble-serial 181-style ALU:
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - S_*         : function-select codes, named after their logic-mode function
//                   (the same codes select the arithmetic (P,Q) pairs)
//   - seg7_hex()  : hex font for a 7-segment digit, {dp,g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
package alu181_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] S_NOT_A       = 4'h0;
    localparam logic [3:0] S_NOR         = 4'h1;
    localparam logic [3:0] S_NOTA_AND_B  = 4'h2;
    localparam logic [3:0] S_ZERO        = 4'h3;
    localparam logic [3:0] S_NAND        = 4'h4;
    localparam logic [3:0] S_NOT_B       = 4'h5;
    localparam logic [3:0] S_XOR         = 4'h6;
    localparam logic [3:0] S_A_ANDNOT_B  = 4'h7;
    localparam logic [3:0] S_NOTA_OR_B   = 4'h8;
    localparam logic [3:0] S_XNOR        = 4'h9;
    localparam logic [3:0] S_B           = 4'hA;
    localparam logic [3:0] S_AND         = 4'hB;
    localparam logic [3:0] S_ONES        = 4'hC;
    localparam logic [3:0] S_A_ORNOT_B   = 4'hD;
    localparam logic [3:0] S_OR          = 4'hE;
    localparam logic [3:0] S_A           = 4'hF;

    // Decimal point is always off, so bit 7 stays 0.
    function automatic logic [7:0] seg7_hex(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu181_slice.sv
// -----------------------------------------------------------------------------
// alu181_slice
// Combinational 4-bit 181-style ALU slice.
// Ports:
//   i_a, i_b  [3:0]  operand nibbles
//   i_s       [3:0]  function select
//   i_m              1 = logic, 0 = arithmetic
//   i_cin            true (active-high) carry in, arithmetic only
//   o_f       [3:0]  result nibble
//   o_cout           true carry out (0 in logic mode)
// Arithmetic is F = P + Q + cin with P,Q bitwise functions of A,B, so chaining
// slices through the carry gives the exact full-width sum.
// -----------------------------------------------------------------------------
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_cin,
    output logic [3:0] o_f,
    output logic       o_cout
);

    logic [3:0] w_logic;
    logic [3:0] w_p;
    logic [3:0] w_q;
    logic [4:0] w_sum;

    always_comb begin
        w_logic = 4'h0;
        case (i_s)
            S_NOT_A:      w_logic = ~i_a;
            S_NOR:        w_logic = ~(i_a | i_b);
            S_NOTA_AND_B: w_logic = ~i_a & i_b;
            S_ZERO:       w_logic = 4'h0;
            S_NAND:       w_logic = ~(i_a & i_b);
            S_NOT_B:      w_logic = ~i_b;
            S_XOR:        w_logic = i_a ^ i_b;
            S_A_ANDNOT_B: w_logic = i_a & ~i_b;
            S_NOTA_OR_B:  w_logic = ~i_a | i_b;
            S_XNOR:       w_logic = ~(i_a ^ i_b);
            S_B:          w_logic = i_b;
            S_AND:        w_logic = i_a & i_b;
            S_ONES:       w_logic = 4'hF;
            S_A_ORNOT_B:  w_logic = i_a | ~i_b;
            S_OR:         w_logic = i_a | i_b;
            default:      w_logic = i_a;
        endcase
    end

    always_comb begin
        w_p = 4'h0;
        w_q = 4'h0;
        case (i_s)
            4'h0: begin w_p = i_a;          w_q = 4'h0;         end
            4'h1: begin w_p = i_a | i_b;    w_q = 4'h0;         end
            4'h2: begin w_p = i_a | ~i_b;   w_q = 4'h0;         end
            4'h3: begin w_p = 4'h0;         w_q = 4'hF;         end
            4'h4: begin w_p = i_a;          w_q = i_a & ~i_b;   end
            4'h5: begin w_p = i_a | i_b;    w_q = i_a & ~i_b;   end
            4'h6: begin w_p = i_a;          w_q = ~i_b;         end
            4'h7: begin w_p = i_a & ~i_b;   w_q = 4'hF;         end
            4'h8: begin w_p = i_a;          w_q = i_a & i_b;    end
            4'h9: begin w_p = i_a;          w_q = i_b;          end
            4'hA: begin w_p = i_a | ~i_b;   w_q = i_a & i_b;    end
            4'hB: begin w_p = i_a & i_b;    w_q = 4'hF;         end
            4'hC: begin w_p = i_a;          w_q = i_a;          end
            4'hD: begin w_p = i_a | i_b;    w_q = i_a;          end
            4'hE: begin w_p = i_a | ~i_b;   w_q = i_a;          end
            default: begin w_p = i_a;       w_q = 4'hF;         end
        endcase
    end

    assign w_sum = {1'b0, w_p} + {1'b0, w_q} + {4'b0000, i_cin};

    always_comb begin
        if (i_m) begin
            o_f    = w_logic;
            o_cout = 1'b0;
        end else begin
            o_f    = w_sum[3:0];
            o_cout = w_sum[4];
        end
    end

endmodule

// File: rtl/alu181_serial.sv
// -----------------------------------------------------------------------------
// alu181_serial
// WIDTH-bit 181-style ALU computed one nibble per clock (LSB nibble first) on a
// single time-shared alu181_slice, carry rippled through a register.
// Parameters: WIDTH (multiple of 4, 4..32), SCAN_DIV (display scan period,
//             used only when ALU181_DISP_EN is defined).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (accept when both high)
//   a_i, b_i, s_i, m_i, cn_n_i   operands, select, mode, active-low carry in
//   out_valid / out_ready        result handshake (consume when both high)
//   f_o, co_o, zero_o, aeqb_o    registered result and flags
//   seg_o, dig_o         7-segment scan outputs (only with ALU181_DISP_EN)
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready
// is high only in IDLE; out_valid is high only in DONE and stays high, with
// f_o and flags stable, until out_ready is seen.
// Configuration macro: ALU181_DISP_EN adds the multiplexed hex display.
// -----------------------------------------------------------------------------
module alu181_serial
    import alu181_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       s_i,
    input  logic             m_i,
    input  logic             cn_n_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f_o,
    output logic             co_o,
    output logic             zero_o,
    output logic             aeqb_o
`ifdef ALU181_DISP_EN
    ,
    output logic [7:0]           seg_o,
    output logic [WIDTH/4-1:0]   dig_o
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_s;
    logic             r_m;
    logic             r_c;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_f;
    logic             r_co;
    logic             r_zero;
    logic             r_aeqb;

    logic [3:0]       w_slice_f;
    logic             w_slice_cout;
    logic             w_last;
    logic [WIDTH+3:0] w_cat;
    logic [WIDTH-1:0] w_full;

    // Operands are shifted right each slice, so the slice always reads nibble 0.
    alu181_slice u_slice (
        .i_a    (r_a[3:0]),
        .i_b    (r_b[3:0]),
        .i_s    (r_s),
        .i_m    (r_m),
        .i_cin  (r_c),
        .o_f    (w_slice_f),
        .o_cout (w_slice_cout)
    );

    assign w_last = (r_k == KW'(NSLICE - 1));

    // Result nibbles enter at the top of r_acc and move down; on the last
    // slice the freshly computed nibble completes the word.
    assign w_cat  = {w_slice_f, r_acc};
    assign w_full = w_cat[WIDTH+3:4];

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= 4'h0;
            r_m    <= 1'b0;
            r_c    <= 1'b0;
            r_k    <= '0;
            r_acc  <= '0;
            r_f    <= '0;
            r_co   <= 1'b0;
            r_zero <= 1'b0;
            r_aeqb <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a <= a_i;
                        r_b <= b_i;
                        r_s <= s_i;
                        r_m <= m_i;
                        // Logic mode never looks at the carry, so forcing
                        // it low keeps the slice carry path quiet.
                        r_c <= ~cn_n_i & ~m_i;
                        r_k <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 4;
                    r_b   <= r_b >> 4;
                    r_c   <= w_slice_cout;
                    r_k   <= r_k + KW'(1);
                    r_acc <= w_full;
                    if (w_last) begin
                        r_f    <= w_full;
                        r_co   <= w_slice_cout;
                        r_zero <= (w_full == '0);
                        r_aeqb <= (w_full == '1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign f_o    = r_f;
    assign co_o   = r_co;
    assign zero_o = r_zero;
    assign aeqb_o = r_aeqb;

`ifdef ALU181_DISP_EN
    // Digit scan: index advances every SCAN_DIV clocks and wraps after the
    // top nibble. The shown value is f_o, i.e. the last completed result.
    logic [31:0]        r_scan_cnt;
    logic [KW-1:0]      r_scan_idx;
    logic [7:0]         r_seg;
    logic [NSLICE-1:0]  r_dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg      <= 8'h00;
            r_dig      <= '1;
        end else begin
            if (r_scan_cnt >= 32'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                if (r_scan_idx == KW'(NSLICE - 1)) r_scan_idx <= '0;
                else                                r_scan_idx <= r_scan_idx + KW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + 32'd1;
            end
            r_dig <= ~(NSLICE'(1) << r_scan_idx);
            r_seg <= seg7_hex(r_f[r_scan_idx*4 +: 4]);
        end
    end

    assign seg_o = r_seg;
    assign dig_o = r_dig;
`endif

endmodule

// File: tb/tb_alu181_serial.sv
module tb_alu181_serial;

    localparam int WIDTH    = 16;
    localparam int NSLICE   = WIDTH / 4;
    localparam int LATENCY  = NSLICE + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [3:0]       s_i;
    logic             m_i;
    logic             cn_n_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f_o;
    logic             co_o;
    logic             zero_o;
    logic             aeqb_o;
`ifdef ALU181_DISP_EN
    logic [7:0]        seg_o;
    logic [NSLICE-1:0] dig_o;
`endif

    alu181_serial #(.WIDTH(WIDTH), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .s_i       (s_i),
        .m_i       (m_i),
        .cn_n_i    (cn_n_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_o       (f_o),
        .co_o      (co_o),
        .zero_o    (zero_o),
        .aeqb_o    (aeqb_o)
`ifdef ALU181_DISP_EN
        ,
        .seg_o     (seg_o),
        .dig_o     (dig_o)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cn_n;
        logic [15:0] f;
        logic        co;
        logic        zero;
        logic        aeqb;
    } vec_t;

    localparam int NV = 27;
    vec_t vt[NV];

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) check({name, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Waits for out_valid, counting edges from the accept edge (accept edge = 1).
    task automatic wait_result(input string name, output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
        check({name, "_latency"}, 32'(cyc), 32'(LATENCY));
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, "_f"},    32'(f_o),    32'(v.f));
        check({name, "_co"},   32'(co_o),   32'(v.co));
        check({name, "_zero"}, 32'(zero_o), 32'(v.zero));
        check({name, "_aeqb"}, 32'(aeqb_o), 32'(v.aeqb));
    endtask

    task automatic drive_op(input vec_t v);
        a_i      = v.a;
        b_i      = v.b;
        s_i      = v.s;
        m_i      = v.m;
        cn_n_i   = v.cn_n;
        in_valid = 1'b1;
    endtask

    task automatic do_op(input string name, input vec_t v);
        int cyc;
        wait_in_ready(name);
        drive_op(v);
        tick();                 // accept edge
        in_valid = 1'b0;
        wait_result(name, cyc);
        check_result(name, v);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        int   cyc;

        //          a        b        s     m     cn_n  f        co    zero  aeqb
        vt[0]  = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{16'h1234, 16'h1234, 4'h6, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{16'h1234, 16'h1234, 4'h6, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{16'hF0F0, 16'hFF00, 4'h3, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{16'h1234, 16'h4321, 4'h9, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{16'h1234, 16'h4321, 4'h9, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{16'hFFFF, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{16'hFFFF, 16'h0000, 4'h0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{16'h0001, 16'h5A5A, 4'hF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[10] = '{16'h8001, 16'h0000, 4'hC, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vt[11] = '{16'h1111, 16'h2222, 4'h3, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[12] = '{16'h1234, 16'h0FF0, 4'hB, 1'b1, 1'b1, 16'h0230, 1'b0, 1'b0, 1'b0};
        vt[13] = '{16'h1234, 16'h0FF0, 4'hE, 1'b1, 1'b1, 16'h1FF4, 1'b0, 1'b0, 1'b0};
        vt[14] = '{16'h1234, 16'h0FF0, 4'hC, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vt[15] = '{16'h1200, 16'h0034, 4'h1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0};
        vt[16] = '{16'h00F0, 16'h0030, 4'h7, 1'b0, 1'b1, 16'h00BF, 1'b1, 1'b0, 1'b0};
        vt[17] = '{16'h0F0F, 16'h00FF, 4'h4, 1'b0, 1'b1, 16'h1E0F, 1'b0, 1'b0, 1'b0};
        vt[18] = '{16'h1111, 16'hABCD, 4'hA, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0};
        vt[19] = '{16'h1234, 16'h0000, 4'h0, 1'b1, 1'b1, 16'hEDCB, 1'b0, 1'b0, 1'b0};
        vt[20] = '{16'hF0F0, 16'hFF00, 4'h2, 1'b1, 1'b1, 16'h0F00, 1'b0, 1'b0, 1'b0};
        vt[21] = '{16'h0005, 16'h0003, 4'h6, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
        vt[22] = '{16'h0100, 16'h0010, 4'hD, 1'b0, 1'b0, 16'h0211, 1'b0, 1'b0, 1'b0};
        vt[23] = '{16'h00F0, 16'h000F, 4'h5, 1'b0, 1'b1, 16'h01EF, 1'b0, 1'b0, 1'b0};
        vt[24] = '{16'hFF00, 16'h0F00, 4'h8, 1'b0, 1'b1, 16'h0E00, 1'b1, 1'b0, 1'b0};
        vt[25] = '{16'h00FF, 16'hFF00, 4'hA, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0};
        vt[26] = '{16'hFFFF, 16'hFFFF, 4'h4, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        s_i       = 4'h0;
        m_i       = 1'b0;
        cn_n_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_f",         32'(f_o),       32'd0);
        check("rst_co",        32'(co_o),      32'd0);
        check("rst_zero",      32'(zero_o),    32'd0);
        check("rst_aeqb",      32'(aeqb_o),    32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            do_op($sformatf("vec%0d", i), vt[i]);
        end

        // Held result: out_ready low for 10 cycles, inputs churn meanwhile.
        v = vt[18];
        wait_in_ready("hold");
        drive_op(v);
        tick();
        a_i = 16'h0000; b_i = 16'h0000; s_i = 4'h3; m_i = 1'b1;   // in_valid still high
        wait_result("hold", cyc);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_f_%0d", i),     32'(f_o),       32'h0000ABCD);
            check($sformatf("hold_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("hold_ready_%0d", i), 32'(in_ready),  32'd0);
            tick();
        end
        check("hold_zero", 32'(zero_o), 32'd0);
        // Handshake with the next request already pending.
        v = vt[5];
        drive_op(v);
        out_ready = 1'b1;
        tick();                 // handshake edge
        out_ready = 1'b0;
        check("b2b_in_ready",  32'(in_ready),  32'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        tick();                 // accept edge
        in_valid = 1'b0;
        check("b2b_accepted",  32'(in_ready),  32'd0);
        wait_result("b2b", cyc);
        check_result("b2b", v);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef ALU181_DISP_EN
        begin
            logic [3:0] exp_dig [4];
            logic [7:0] exp_seg [4];
            int n;
            do_op("disp_load", vt[18]);   // f_o = ABCD
            exp_dig[0] = 4'hE; exp_dig[1] = 4'hD; exp_dig[2] = 4'hB; exp_dig[3] = 4'h7;
            exp_seg[0] = 8'h5E; exp_seg[1] = 8'h7C; exp_seg[2] = 8'h39; exp_seg[3] = 8'h77;
            n = 0;
            while (dig_o != 4'h7 && n < 40) begin tick(); n++; end
            while (dig_o != 4'hE && n < 40) begin tick(); n++; end
            for (int d = 0; d < 4; d++) begin
                check($sformatf("disp_dig_%0d", d), 32'(dig_o), 32'(exp_dig[d]));
                check($sformatf("disp_seg_%0d", d), 32'(seg_o), 32'(exp_seg[d]));
                repeat (4) tick();
            end
        end
`endif

        // Reset during the second RUN cycle; f_o holds a nonzero result before.
        do_op("pre_rst", vt[18]);
        v = vt[5];
        wait_in_ready("midrst");
        drive_op(v);
        tick();                 // accept -> RUN (first RUN cycle)
        in_valid = 1'b0;
        tick();                 // second RUN cycle
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_f",         32'(f_o),       32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_aeqb",      32'(aeqb_o),    32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("midrst_stale_%0d", i), 32'(out_valid), 32'd0);
        end
        check("midrst_f_after", 32'(f_o), 32'd0);
        do_op("post_rst", vt[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
